// File: rtl/bz_host_core_pll_rst_ctrl.sv
// Host-core PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the core reset.
// Optional `PLL_RST_CTRL_FORCE_EN adds a synchronous force_relock input.
module bz_host_core_pll_rst_ctrl #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES         = 8,
  parameter int unsigned CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
`ifdef PLL_RST_CTRL_FORCE_EN
  input  logic       force_relock,
`endif
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [7:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_lock_sync;
  logic             w_lock_s;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_retry_cnt;
  logic [7:0]       w_retry_nxt;
  logic [7:0]       w_retry_inc;

  // Assertion is immediate; release is retimed to refclk so the FSM never sees a partial release.
  // NOTE: sequential state is always written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) r_lock_sync <= 2'b00;
    else          r_lock_sync <= {r_lock_sync[0], pll_locked};
  end
  assign w_lock_s = r_lock_sync[1];

  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_retry_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry_cnt <= w_retry_nxt;
    end
  end

  assign w_retry_inc = (r_retry_cnt == 8'hFF) ? r_retry_cnt : r_retry_cnt + 8'd1;

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_retry_nxt = r_retry_cnt;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == C_RST_LAST) w_state_nxt = S_WAIT_LOCK;
        else                     w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_retry_nxt = w_retry_inc;
          if ((MAX_RETRIES != 0) && (32'(w_retry_inc) >= MAX_RETRIES)) w_state_nxt = S_FAIL;
          else                                                         w_state_nxt = S_PLL_RST;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A lock drop while qualifying is not a timeout, so retry_cnt is left alone.
        if (!w_lock_s)                     w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == C_STABLE_LAST)   w_state_nxt = S_RUN;
        else                               w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_RUN: begin
        if (!w_lock_s) w_state_nxt = S_PLL_RST;
      end
      S_FAIL:  w_state_nxt = S_FAIL;
      default: w_state_nxt = S_PLL_RST;
    endcase
`ifdef PLL_RST_CTRL_FORCE_EN
    if (force_relock && (r_state != S_FAIL)) begin
      w_state_nxt = S_PLL_RST;
      w_cnt_nxt   = '0;
      w_retry_nxt = r_retry_cnt;
    end
`endif
  end

  assign pll_rst    = (r_state == S_PLL_RST) || (r_state == S_FAIL);
  assign core_rst_n = (r_state == S_RUN);
  assign ready      = (r_state == S_RUN);
  assign fail       = (r_state == S_FAIL);
  assign retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_bz_host_core_pll_rst_ctrl.sv
// Self-checking bench for bz_host_core_pll_rst_ctrl: directed scenarios plus random lock
// activity, compared every cycle against a phase/age reference model.
`timescale 1ns/1ps
module tb_bz_host_core_pll_rst_ctrl;

  localparam int unsigned PRC = 4;
  localparam int unsigned LSC = 8;
  localparam int unsigned LTC = 32;
  localparam int unsigned MR  = 3;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic       fail;
  logic [7:0] retry_cnt;
`ifdef PLL_RST_CTRL_FORCE_EN
  logic       force_relock = 1'b0;
`endif

  bz_host_core_pll_rst_ctrl #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES        (MR),
    .CNT_W              (17)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
`ifdef PLL_RST_CTRL_FORCE_EN
    .force_relock(force_relock),
`endif
    .pll_rst   (pll_rst),
    .core_rst_n(core_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  always #5 refclk = ~refclk;

  // Reference model: current phase plus the number of edges spent in it.
  typedef enum int {M_PLL_RST, M_WAIT, M_STABLE, M_RUN, M_FAIL} phase_e;
  phase_e m_phase = M_PLL_RST;
  int     m_age   = 0;
  int     m_rel   = 0;
  int     m_retry = 0;
  logic   m_s1    = 1'b0;
  logic   m_s2    = 1'b0;
  int     m_retry_next;

  assign m_retry_next = (m_retry < 255) ? m_retry + 1 : 255;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= M_PLL_RST;
      m_age   <= 0;
      m_rel   <= 0;
      m_retry <= 0;
      m_s1    <= 1'b0;
      m_s2    <= 1'b0;
    end else if (m_rel < 2) begin
      m_rel <= m_rel + 1;
      m_age <= 0;
    end else begin
      m_s1  <= pll_locked;
      m_s2  <= m_s1;
      m_age <= m_age + 1;
      case (m_phase)
        M_PLL_RST: if (m_age + 1 == PRC) begin m_phase <= M_WAIT; m_age <= 0; end
        M_WAIT: begin
          if (m_s2) begin
            m_phase <= M_STABLE; m_age <= 0;
          end else if (m_age + 1 == LTC) begin
            m_retry <= m_retry_next;
            m_age   <= 0;
            if (MR != 0 && m_retry_next >= MR) m_phase <= M_FAIL;
            else                               m_phase <= M_PLL_RST;
          end
        end
        M_STABLE: begin
          if (!m_s2)                  begin m_phase <= M_WAIT; m_age <= 0; end
          else if (m_age + 1 == LSC)  begin m_phase <= M_RUN;  m_age <= 0; end
        end
        M_RUN:   if (!m_s2) begin m_phase <= M_PLL_RST; m_age <= 0; end
        default: m_age <= 0;
      endcase
    end
  end

  logic [11:0] w_obs;
  logic [11:0] w_exp;
  assign w_obs = {pll_rst, core_rst_n, ready, fail, retry_cnt};
  assign w_exp = {(m_phase == M_PLL_RST) || (m_phase == M_FAIL), m_phase == M_RUN,
                  m_phase == M_RUN, m_phase == M_FAIL, 8'(m_retry)};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge refclk);
      check("cycle", w_obs, w_exp);
    end
  endtask

  task automatic wait_phase(input phase_e ph, input int age, input int limit, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge refclk);
      check("cycle", w_obs, w_exp);
      if (m_phase == ph && m_age == age) hit = 1'b1;
    end
    check(tag, {11'd0, hit}, 12'd1);
  endtask

  initial begin
    int lat;
    bit got;

    // Reset state
    repeat (3) @(negedge refclk);
    check("reset_values", w_obs, 12'h800);

    // Scenario 1: first release, lock arrives 10 cycles after rst_n
    rst_n = 1'b1;
    step(10);
    pll_locked = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge refclk);
      check("cycle", w_obs, w_exp);
      if (core_rst_n) begin got = 1'b1; lat = i - 1; end
    end
    check("release_latency", 12'(lat), 12'(2 + LSC));
    check("ready_in_run", {3'd0, ready, retry_cnt}, {3'd0, 1'b1, 8'd0});

    // Scenario 2: lock loss in RUN for 5 cycles
    pll_locked = 1'b0;
    step(2);
    check("run_drop_hold", {11'd0, core_rst_n}, 12'd1);
    step(1);
    check("run_drop_fall", {10'd0, pll_rst, core_rst_n}, 12'b10);
    step(2);
    pll_locked = 1'b1;
    step(30);
    check("relock_ready", {11'd0, ready}, 12'd1);

    // Scenario 3: one-cycle lock glitch while qualifying
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    wait_phase(M_STABLE, 3, 60, "reach_stable");
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(3);
    check("glitch_no_release", {11'd0, core_rst_n}, 12'd0);
    step(20);
    check("glitch_relock", {3'd0, ready, retry_cnt}, {3'd0, 1'b1, 8'd0});

    // Random lock activity with occasional resets
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end else begin
        pll_locked = ($urandom_range(0, 3) != 0);
        step($urandom_range(1, 45));
      end
    end

    // Scenario 4: lock never arrives -> three timeouts then FAIL
    rst_n = 1'b0;
    pll_locked = 1'b0;
    step(2);
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge refclk);
      check("cycle", w_obs, w_exp);
      if (fail) got = 1'b1;
    end
    check("fail_reached", {11'd0, got}, 12'd1);
    check("fail_outputs", w_obs, {1'b1, 1'b0, 1'b0, 1'b1, 8'd3});
    pll_locked = 1'b1;
    step(20);
    check("fail_terminal", w_obs, {1'b1, 1'b0, 1'b0, 1'b1, 8'd3});

    // Scenario 5: asynchronous reset in STABLE at count 6
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    wait_phase(M_STABLE, 6, 100, "reach_stable6");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", w_obs, 12'h800);
    @(negedge refclk);
    rst_n = 1'b1;
    step(30);
    check("restart_ready", {3'd0, ready, retry_cnt}, {3'd0, 1'b1, 8'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
